// File: rtl/resolution_overlay.sv
// resolution_overlay
// Fetches one row of the resolution-text character ROM during horizontal
// blank of every line that crosses the overlay window. It then serializes
// that row MSB-first, with pixel and line scaling, into a per-pixel overlay
// bit for the video mixer.
//
// Ports
//   clock         pixel clock, all logic on the rising edge
//   reset         synchronous, active-high
//   line_start    one-cycle pulse in horizontal blank, before the line's first de
//   line_y        y of the upcoming active line, sampled with line_start
//   de            active-video enable
//   pixel_x       x of the current pixel (meaningful when de=1)
//   rom_addr      registered row address to the character ROM
//   rom_q         ROM row data, valid one cycle after rom_addr changes
//   overlay_on    current pixel is inside the window on a fetched line
//   overlay_pixel glyph bit for the current pixel, 0 when overlay_on=0
//   busy          a row fetch is in progress
//
// State table
//   state | meaning
//   IDLE  | line outside the window, or nothing fetched yet; outputs held at 0
//   ADDR  | rom_addr holds the row; the ROM registers it this cycle
//   WAIT  | rom_q is valid; it is captured into the line buffer at cycle end
//   READY | line buffer valid; pixels are serialized from it
module resolution_overlay #(
    parameter int LINE_WIDTH = 136,
    parameter int X_POS      = 16,
    parameter int Y_POS      = 16,
    parameter int SCALE_LOG2 = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [11:0]           line_y,
    input  logic                  de,
    input  logic [11:0]           pixel_x,
    output logic [3:0]            rom_addr,
    input  logic [LINE_WIDTH-1:0] rom_q,
    output logic                  overlay_on,
    output logic                  overlay_pixel,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_READY
    } state_e;

    localparam logic [12:0] Y_LO = 13'(Y_POS);
    localparam logic [12:0] Y_HI = 13'(Y_POS + (16 << SCALE_LOG2));
    localparam logic [12:0] X_LO = 13'(X_POS);
    localparam logic [12:0] X_HI = 13'(X_POS + (LINE_WIDTH << SCALE_LOG2));
    localparam logic [LINE_WIDTH-1:0] MSB_ONE = {1'b1, {(LINE_WIDTH-1){1'b0}}};

    state_e                state_q, state_d;
    logic [3:0]            addr_q, addr_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    logic                  on_q, on_d;
    logic                  pix_q, pix_d;

    logic [12:0]           y_ext, y_off;
    logic [12:0]           x_ext, x_off;
    logic                  y_in, x_in;
    logic [3:0]            row;
    logic [7:0]            col;
    logic [LINE_WIDTH-1:0] col_sel;

    // Window decode. Offsets are only formed once the lower bound is known
    // to hold, so row and col never see a wrapped subtraction.
    always_comb begin
        y_ext   = {1'b0, line_y};
        y_in    = (y_ext >= Y_LO) && (y_ext < Y_HI);
        y_off   = y_in ? (y_ext - Y_LO) : 13'd0;
        row     = 4'(y_off >> SCALE_LOG2);

        x_ext   = {1'b0, pixel_x};
        x_in    = de && (x_ext >= X_LO) && (x_ext < X_HI);
        x_off   = x_in ? (x_ext - X_LO) : 13'd0;
        col     = 8'(x_off >> SCALE_LOG2);

        // Walks a one-hot mask from the MSB down, giving buf[LINE_WIDTH-1-col].
        col_sel = MSB_ONE >> col;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        on_d    = 1'b0;
        pix_d   = 1'b0;

        // line_start wins over everything, so an in-flight fetch is dropped
        // before its WAIT capture can load a stale row.
        if (line_start) begin
            if (y_in) begin
                state_d = S_ADDR;
                addr_d  = row;
            end else begin
                state_d = S_IDLE;
                buf_d   = '0;
            end
        end else begin
            case (state_q)
                S_ADDR:  state_d = S_WAIT;
                S_WAIT: begin
                    buf_d   = rom_q;
                    state_d = S_READY;
                end
                default: state_d = state_q;
            endcase
        end

        if (state_q == S_READY && x_in) begin
            on_d  = 1'b1;
            pix_d = |(buf_q & col_sel);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 4'd0;
            buf_q   <= '0;
            on_q    <= 1'b0;
            pix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            on_q    <= on_d;
            pix_q   <= pix_d;
        end
    end

    assign rom_addr      = addr_q;
    assign overlay_on    = on_q;
    assign overlay_pixel = pix_q;
    assign busy          = (state_q == S_ADDR) || (state_q == S_WAIT);

endmodule

// File: tb/tb_resolution_overlay.sv
// Bench for resolution_overlay: two instances (scale 1x and 2x) share the
// video timing inputs; each has its own registered character ROM.
module tb_resolution_overlay;

    localparam int LW = 136;

    logic          clock = 1'b0;
    logic          reset;
    logic          line_start;
    logic [11:0]   line_y;
    logic          de;
    logic [11:0]   pixel_x;
    logic [3:0]    rom_addr0, rom_addr1;
    logic [LW-1:0] rom_q0, rom_q1;
    logic          on0, on1, pix0, pix1, busy0, busy1;

    logic [LW-1:0] rom_mem [16];

    int checks = 0;
    int errors = 0;

    // Model state: rows held per instance, whether the line is in the window,
    // and how many clock edges have passed since the last accepted line_start.
    bit            m_valid [2];
    logic [LW-1:0] m_buf   [2];
    logic [3:0]    m_addr  [2];
    int            age;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rom_q0 <= rom_mem[rom_addr0];
        rom_q1 <= rom_mem[rom_addr1];
    end

    resolution_overlay #(.LINE_WIDTH(LW), .X_POS(16), .Y_POS(16), .SCALE_LOG2(0)) dut0 (
        .clock(clock), .reset(reset), .line_start(line_start), .line_y(line_y),
        .de(de), .pixel_x(pixel_x), .rom_addr(rom_addr0), .rom_q(rom_q0),
        .overlay_on(on0), .overlay_pixel(pix0), .busy(busy0)
    );

    resolution_overlay #(.LINE_WIDTH(LW), .X_POS(16), .Y_POS(16), .SCALE_LOG2(1)) dut1 (
        .clock(clock), .reset(reset), .line_start(line_start), .line_y(line_y),
        .de(de), .pixel_x(pixel_x), .rom_addr(rom_addr1), .rom_q(rom_q1),
        .overlay_on(on1), .overlay_pixel(pix1), .busy(busy1)
    );

    task automatic fill_rom();
        for (int r = 0; r < 16; r++)
            rom_mem[r] = LW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    // Advance one clock edge and update the reference model with what the
    // edge sampled.
    task automatic tick();
        bit r, ls;
        int y;
        r  = reset;
        ls = line_start;
        y  = int'(line_y);
        @(posedge clock);
        if (r) begin
            for (int s = 0; s < 2; s++) begin
                m_valid[s] = 1'b0;
                m_addr[s]  = 4'd0;
                m_buf[s]   = '0;
            end
            age = 1000;
        end else if (ls) begin
            age = 0;
            for (int s = 0; s < 2; s++) begin
                if (y >= 16 && y < 16 + (16 << s)) begin
                    m_valid[s] = 1'b1;
                    m_addr[s]  = 4'((y - 16) >> s);
                    m_buf[s]   = rom_mem[(y - 16) >> s];
                end else begin
                    m_valid[s] = 1'b0;
                end
            end
        end else if (age < 1000) begin
            age++;
        end
        #1;
    endtask

    // Expected {overlay_pixel, overlay_on} for the pixel currently on the inputs.
    // The row becomes usable once three edges have passed since line_start.
    function automatic logic [1:0] exp_out(int s);
        int px;
        px = int'(pixel_x);
        if (reset || !m_valid[s] || age < 2 || !de || px < 16 || px >= 16 + (LW << s))
            return 2'b00;
        return {m_buf[s][LW - 1 - ((px - 16) >> s)], 1'b1};
    endfunction

    function automatic bit exp_busy(int s);
        return m_valid[s] && age < 2;
    endfunction

    task automatic start_line(int y);
        line_start = 1'b1;
        line_y     = 12'(y);
        de         = 1'b0;
        tick();
        line_start = 1'b0;
    endtask

    task automatic test_reset();
        fill_rom();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            line_start = 1'($urandom());
            line_y     = 12'($urandom());
            de         = 1'($urandom());
            pixel_x    = 12'($urandom());
            tick();
            checks++;
            if ({rom_addr0, rom_addr1, on0, on1, pix0, pix1, busy0, busy1} !== 12'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got addr0=%0d addr1=%0d on=%b%b pix=%b%b busy=%b%b required all 0",
                         i, rom_addr0, rom_addr1, on0, on1, pix0, pix1, busy0, busy1);
            end
        end
        reset      = 1'b0;
        line_start = 1'b0;
        de         = 1'b1;
        pixel_x    = 12'd16;
        tick();
        checks++;
        if ({on0, on1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_pixel got on=%b%b required 00", on0, on1);
        end
        de = 1'b0;
        tick();
    endtask

    task automatic test_row_mapping();
        int ys   [4] = '{21, 47, 48, 15};
        int rows [4] = '{2, 15, 15, 15};
        bit fet  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            start_line(ys[i]);
            checks++;
            if (rom_addr1 !== 4'(rows[i]) || busy1 !== fet[i]) begin
                errors++;
                $display("FAIL row_map_t1 y=%0d got addr=%0d busy=%b required addr=%0d busy=%b",
                         ys[i], rom_addr1, busy1, rows[i], fet[i]);
            end
            checks++;
            if (rom_addr0 !== m_addr[0] || busy0 !== exp_busy(0)) begin
                errors++;
                $display("FAIL row_map_s0 y=%0d got addr=%0d busy=%b required addr=%0d busy=%b",
                         ys[i], rom_addr0, busy0, m_addr[0], exp_busy(0));
            end
            tick();
            checks++;
            if (busy1 !== fet[i]) begin
                errors++;
                $display("FAIL row_map_t2 y=%0d got busy=%b required %b", ys[i], busy1, fet[i]);
            end
            tick();
            checks++;
            if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL row_map_t3 y=%0d got busy=%b%b required 00", ys[i], busy0, busy1);
            end
            tick();
        end
    endtask

    task automatic test_serialization();
        logic [LW-1:0] pat;
        logic [1:0]    e0, e1;
        pat       = '0;
        pat[LW-1] = 1'b1;
        pat[0]    = 1'b1;
        rom_mem[5] = pat;   // row for y=21 at 1x
        rom_mem[2] = pat;   // row for y=21 at 2x
        start_line(21);
        tick();
        tick();
        for (int px = 10; px < 292; px++) begin
            de      = 1'b1;
            pixel_x = 12'(px);
            e0 = exp_out(0);
            e1 = exp_out(1);
            tick();
            checks++;
            if ({pix0, on0} !== e0 || {pix1, on1} !== e1) begin
                errors++;
                $display("FAIL serialize px=%0d got s0=%b%b s1=%b%b required s0=%b s1=%b",
                         px, pix0, on0, pix1, on1, e0, e1);
            end
        end
        de = 1'b0;
        tick();
    endtask

    task automatic test_early_pixel();
        fill_rom();
        start_line(30);
        tick();
        de      = 1'b1;
        pixel_x = 12'd16;
        tick();
        checks++;
        if ({on0, on1} !== 2'b00) begin
            errors++;
            $display("FAIL early_pixel got on=%b%b required 00", on0, on1);
        end
        tick();
        checks++;
        if ({on0, on1} !== 2'b11) begin
            errors++;
            $display("FAIL first_ready_pixel got on=%b%b required 11", on0, on1);
        end
        de = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [1:0] e0, e1;
        fill_rom();
        // Restart with a different in-window row while in WAIT.
        start_line(20);
        tick();
        start_line(25);
        tick();
        tick();
        for (int px = 14; px < 160; px++) begin
            de      = 1'b1;
            pixel_x = 12'(px);
            e0 = exp_out(0);
            e1 = exp_out(1);
            tick();
            checks++;
            if ({pix0, on0} !== e0 || {pix1, on1} !== e1) begin
                errors++;
                $display("FAIL restart_row px=%0d got s0=%b%b s1=%b%b required s0=%b s1=%b",
                         px, pix0, on0, pix1, on1, e0, e1);
            end
        end
        de = 1'b0;
        tick();
        // Abandon with an out-of-window line during WAIT.
        start_line(20);
        tick();
        start_line(100);
        checks++;
        if ({busy0, busy1} !== 2'b00) begin
            errors++;
            $display("FAIL abort_busy got busy=%b%b required 00", busy0, busy1);
        end
        tick();
        tick();
        for (int px = 14; px < 300; px += 3) begin
            de      = 1'b1;
            pixel_x = 12'(px);
            tick();
            checks++;
            if ({on0, on1, pix0, pix1} !== 4'b0000) begin
                errors++;
                $display("FAIL abort_line px=%0d got on=%b%b pix=%b%b required 0", px, on0, on1, pix0, pix1);
            end
        end
        de = 1'b0;
        tick();
    endtask

    task automatic test_reset_midline();
        start_line(20);
        tick();
        tick();
        de      = 1'b1;
        pixel_x = 12'd20;
        tick();
        checks++;
        if ({on0, on1} !== 2'b11) begin
            errors++;
            $display("FAIL midline_pre got on=%b%b required 11", on0, on1);
        end
        reset   = 1'b1;
        pixel_x = 12'd21;
        tick();
        reset = 1'b0;
        checks++;
        if ({on0, on1, pix0, pix1, busy0, busy1} !== 6'd0) begin
            errors++;
            $display("FAIL midline_reset got on=%b%b pix=%b%b busy=%b%b required 0",
                     on0, on1, pix0, pix1, busy0, busy1);
        end
        for (int px = 22; px < 60; px++) begin
            pixel_x = 12'(px);
            tick();
            checks++;
            if ({on0, on1} !== 2'b00) begin
                errors++;
                $display("FAIL midline_hold px=%0d got on=%b%b required 00", px, on0, on1);
            end
        end
        start_line(20);
        tick();
        tick();
        de      = 1'b1;
        pixel_x = 12'd20;
        tick();
        checks++;
        if ({on0, on1} !== 2'b11) begin
            errors++;
            $display("FAIL midline_refetch got on=%b%b required 11", on0, on1);
        end
        de = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [1:0] e0, e1;
        int         pulses, gap;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0)
                fill_rom();
            pulses = $urandom_range(1, 2);
            for (int p = 0; p < pulses; p++) begin
                start_line($urandom_range(0, 60));
                checks++;
                if (busy0 !== exp_busy(0) || busy1 !== exp_busy(1) ||
                    rom_addr0 !== m_addr[0] || rom_addr1 !== m_addr[1]) begin
                    errors++;
                    $display("FAIL rand_fetch y=%0d got busy=%b%b addr=%0d/%0d required busy=%b%b addr=%0d/%0d",
                             line_y, busy0, busy1, rom_addr0, rom_addr1,
                             exp_busy(0), exp_busy(1), m_addr[0], m_addr[1]);
                end
            end
            gap = $urandom_range(0, 4);
            for (int k = 0; k < gap + 30; k++) begin
                de      = ($urandom_range(0, 5) != 0);
                pixel_x = 12'(k < gap ? $urandom_range(10, 40) : $urandom_range(0, 300));
                e0 = exp_out(0);
                e1 = exp_out(1);
                tick();
                checks++;
                if ({pix0, on0} !== e0 || {pix1, on1} !== e1 ||
                    busy0 !== exp_busy(0) || busy1 !== exp_busy(1)) begin
                    errors++;
                    $display("FAIL rand_pixel n=%0d px=%0d got s0=%b%b s1=%b%b busy=%b%b required s0=%b s1=%b busy=%b%b",
                             n, pixel_x, pix0, on0, pix1, on1, busy0, busy1,
                             e0, e1, exp_busy(0), exp_busy(1));
                end
            end
            de = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        line_start = 1'b0;
        line_y     = 12'd0;
        de         = 1'b0;
        pixel_x    = 12'd0;
        age        = 1000;
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 1'b0;
            m_addr[s]  = 4'd0;
            m_buf[s]   = '0;
        end
        #1;
        test_reset();
        test_row_mapping();
        test_serialization();
        test_early_pixel();
        test_abort();
        test_reset_midline();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
